// File: rtl/ibex_data_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ibex_data_sram_bridge
// Purpose  : Single-outstanding bridge from the core data port (req/gnt/rvalid)
//            to one single-port synchronous SRAM. Decodes one address window,
//            adds WAIT_STATES extra response cycles, and answers out-of-window
//            accesses with an error response that never touches the SRAM.
// Ports    :
//   clk_i, rst_i           clock, asynchronous active-high reset
//   data_req_i/gnt_o       core request / grant
//   data_rvalid_o          one-cycle response strobe per granted request
//   data_we_i/be_i         write enable / byte enables
//   data_addr_i/wdata_i    byte address (bits [1:0] ignored) / write data
//   data_rdata_o           read data (zero for writes, errors, and idle)
//   data_rdata_intg_o      read-data integrity, tied to zero
//   data_err_o             error flag, qualified by data_rvalid_o
//   mem_*                  SRAM strobe, write, byte mask, word address, data
//   mem_rdata_i            SRAM read data, valid the cycle after mem_req_o
//   err_count_o            saturating count of error responses
// Revision : 1.0 - initial release
// ============================================================================
module ibex_data_sram_bridge #(
  parameter logic [31:0] ADDR_BASE   = 32'h0010_0000,
  parameter int unsigned MEM_WORDS   = 4096,
  parameter int unsigned AW          = $clog2(MEM_WORDS),
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          data_req_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [31:0]   data_addr_i,
  input  logic [31:0]   data_wdata_i,
  output logic [31:0]   data_rdata_o,
  output logic [6:0]    data_rdata_intg_o,
  output logic          data_err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  output logic [15:0]   err_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] WIN_BYTES = 32'(4 * MEM_WORDS);
  localparam logic [2:0]  WS_LOAD   = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);
  // With no wait states the response lands exactly when the SRAM output is
  // valid, so it is forwarded directly instead of through the hold register.
  localparam bit          DIRECT    = (WAIT_STATES == 0);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q;
  logic        err_q;
  logic        cap_q;
  logic [31:0] hold_q;
  logic [15:0] err_cnt_q;

  logic        gnt;
  logic        in_range;
  logic [31:0] offset;
  logic        rvalid;
  logic [31:0] rd_src;

  // Unsigned subtraction makes addresses below the base wrap to a huge
  // offset, so a single compare rejects both sides of the window.
  assign offset   = data_addr_i - ADDR_BASE;
  assign in_range = (offset < WIN_BYTES);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (data_req_i) begin
          gnt = 1'b1;
          if (DIRECT) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      cap_q     <= 1'b0;
      hold_q    <= 32'd0;
      err_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= gnt;
      if (gnt) begin
        we_q  <= data_we_i;
        err_q <= ~in_range;
      end
      // cap_q marks the cycle after a grant, when the SRAM output is valid.
      if (cap_q) begin
        hold_q <= mem_rdata_i;
      end
      if (rvalid && err_q && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign rvalid = (state_q == ST_RESP);
  assign rd_src = DIRECT ? mem_rdata_i : hold_q;

  assign data_gnt_o        = gnt;
  assign data_rvalid_o     = rvalid;
  assign data_err_o        = rvalid & err_q;
  assign data_rdata_o      = (rvalid && !we_q && !err_q) ? rd_src : 32'd0;
  assign data_rdata_intg_o = 7'h0;
  assign err_count_o       = err_cnt_q;

  assign mem_req_o   = gnt & in_range;
  assign mem_we_o    = gnt & in_range & data_we_i;
  assign mem_be_o    = data_be_i;
  assign mem_addr_o  = data_addr_i[AW+1:2];
  assign mem_wdata_o = data_wdata_i;

endmodule
`default_nettype wire

// File: tb/tb_ibex_data_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_data_sram_bridge
// Purpose  : Self-checking bench for ibex_data_sram_bridge. Three instances run
//            with 0, 3 and 5 wait states, each behind a simple SRAM model.
//            Expected responses come from a word-level shadow memory and the
//            window/latency rules, not from the bridge's internal structure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_data_sram_bridge;

  localparam logic [31:0] BASE  = 32'h0010_0000;
  localparam int          WORDS = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req   [3];
  logic        we    [3];
  logic [3:0]  be    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        gnt   [3];
  logic        rvalid[3];
  logic [31:0] rdata [3];
  logic [6:0]  intg  [3];
  logic        err   [3];
  logic        mreq  [3];
  logic        mwe   [3];
  logic [3:0]  mbe   [3];
  logic [11:0] maddr [3];
  logic [31:0] mwdata[3];
  logic [15:0] errcnt[3];

  int checks   = 0;
  int failures = 0;
  int exp_errs [3];
  logic [31:0] shadow [int];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
    logic [31:0] mem [WORDS];
    logic [31:0] mrd;

    initial begin
      for (int i = 0; i < WORDS; i++) mem[i] = '0;
      mrd = '0;
    end

    always @(posedge clk) begin
      if (mreq[g]) begin
        if (mwe[g]) begin
          for (int b = 0; b < 4; b++)
            if (mbe[g][b]) mem[maddr[g]][8*b +: 8] <= mwdata[g][8*b +: 8];
        end else begin
          mrd <= mem[maddr[g]];
        end
      end
    end

    ibex_data_sram_bridge #(
      .ADDR_BASE  (BASE),
      .MEM_WORDS  (WORDS),
      .WAIT_STATES(WS)
    ) u_dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .data_req_i       (req[g]),
      .data_gnt_o       (gnt[g]),
      .data_rvalid_o    (rvalid[g]),
      .data_we_i        (we[g]),
      .data_be_i        (be[g]),
      .data_addr_i      (addr[g]),
      .data_wdata_i     (wdata[g]),
      .data_rdata_o     (rdata[g]),
      .data_rdata_intg_o(intg[g]),
      .data_err_o       (err[g]),
      .mem_req_o        (mreq[g]),
      .mem_we_o         (mwe[g]),
      .mem_be_o         (mbe[g]),
      .mem_addr_o       (maddr[g]),
      .mem_wdata_o      (mwdata[g]),
      .mem_rdata_i      (mrd),
      .err_count_o      (errcnt[g])
    );
  end

  // ---------------- reference model helpers ----------------
  function automatic int ws_of(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 3 : 5);
  endfunction

  function automatic bit win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd16384);
  endfunction

  function automatic int key(input int g, input logic [31:0] a);
    return g * 65536 + int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] shadow_rd(input int g, input logic [31:0] a);
    int k = key(g, a);
    return shadow.exists(k) ? shadow[k] : 32'd0;
  endfunction

  task automatic shadow_wr(input int g, input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] d);
    logic [31:0] v = shadow_rd(g, a);
    for (int i = 0; i < 4; i++) if (b[i]) v[8*i +: 8] = d[8*i +: 8];
    shadow[key(g, a)] = v;
  endtask

  // Drives one request, waits for its grant and response (both bounded).
  // lat is the response cycle counted from the grant cycle, -1 on timeout.
  task automatic issue(input int g, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic e,
                       output logic mq, output logic [11:0] ma);
    lat = -1; rd = '0; e = 1'b0; mq = 1'b0; ma = '0;
    @(negedge clk);
    req[g] = 1'b1; we[g] = w; be[g] = b; addr[g] = a; wdata[g] = d;
    #1;
    for (int i = 0; i < 20 && !gnt[g]; i++) begin
      @(negedge clk); #1;
    end
    if (!gnt[g]) begin
      req[g] = 1'b0;
      return;
    end
    mq = mreq[g];
    ma = maddr[g];
    if (w && win(a)) shadow_wr(g, a, b, d);
    @(negedge clk);
    req[g] = 1'b0;
    #1;
    for (int k = 1; k <= 20; k++) begin
      if (rvalid[g]) begin
        lat = k; rd = rdata[g]; e = err[g];
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (rvalid[g] !== 1'b0 || err[g] !== 1'b0 || rdata[g] !== 32'd0 ||
          errcnt[g] !== 16'd0 || mreq[g] !== 1'b0 || intg[g] !== 7'h0) begin
        failures++;
        $display("FAIL reset_state inst=%0d rvalid=%b err=%b rdata=%h errcnt=%0d mreq=%b intg=%h (want all zero)",
                 g, rvalid[g], err[g], rdata[g], errcnt[g], mreq[g], intg[g]);
      end
    end
  endtask

  task automatic test_write_read;
    int lat; logic [31:0] rd; logic e, mq; logic [11:0] ma;
    issue(0, 1'b1, 4'hF, 32'h0010_0010, 32'hDEAD_BEEF, lat, rd, e, mq, ma);
    checks++;
    if (lat !== 1 || mq !== 1'b1 || ma !== 12'd4 || e !== 1'b0 || rd !== 32'd0) begin
      failures++;
      $display("FAIL ws0_write lat=%0d mreq=%b maddr=%0d err=%b rdata=%h (want 1 1 4 0 0)",
               lat, mq, ma, e, rd);
    end
    issue(0, 1'b0, 4'hF, 32'h0010_0010, 32'h0, lat, rd, e, mq, ma);
    checks++;
    if (lat !== 1 || mq !== 1'b1 || ma !== 12'd4 || e !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL ws0_read lat=%0d mreq=%b maddr=%0d err=%b rdata=%h (want 1 1 4 0 deadbeef)",
               lat, mq, ma, e, rd);
    end
  endtask

  task automatic test_byte_enable;
    int lat; logic [31:0] rd; logic e, mq; logic [11:0] ma;
    issue(0, 1'b1, 4'hF, 32'h0010_0020, 32'hFFFF_FFFF, lat, rd, e, mq, ma);
    issue(0, 1'b1, 4'b0010, 32'h0010_0020, 32'h0000_AB00, lat, rd, e, mq, ma);
    issue(0, 1'b0, 4'hF, 32'h0010_0020, 32'h0, lat, rd, e, mq, ma);
    checks++;
    if (rd !== 32'hFFFF_ABFF || lat !== 1) begin
      failures++;
      $display("FAIL byte_enable rdata=%h lat=%0d (want ffffabff 1)", rd, lat);
    end
  endtask

  task automatic test_out_of_range;
    int lat; logic [31:0] rd; logic e, mq; logic [11:0] ma;
    logic [31:0] bad [2];
    bad[0] = 32'h0010_4000;
    bad[1] = 32'h000F_FFFC;
    for (int i = 0; i < 2; i++) begin
      issue(0, 1'b0, 4'hF, bad[i], 32'h0, lat, rd, e, mq, ma);
      exp_errs[0]++;
      checks++;
      if (mq !== 1'b0 || lat !== 1 || e !== 1'b1 || rd !== 32'd0) begin
        failures++;
        $display("FAIL out_of_range addr=%h mreq=%b lat=%0d err=%b rdata=%h (want 0 1 1 0)",
                 bad[i], mq, lat, e, rd);
      end
      @(negedge clk); #1;
      checks++;
      if (errcnt[0] !== 16'(exp_errs[0])) begin
        failures++;
        $display("FAIL err_count got=%0d want=%0d", errcnt[0], exp_errs[0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] rd; logic e, mq; logic [11:0] ma;
    logic [31:0] d [4];
    for (int j = 0; j < 4; j++) begin
      d[j] = $urandom;
      issue(0, 1'b1, 4'hF, BASE + 32'h40 + 32'(4*j), d[j], lat, rd, e, mq, ma);
    end
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = BASE + 32'h40 + 32'(4*k);
      end else begin
        req[0] = 1'b0;
      end
      #1;
      if (k < 4) begin
        checks++;
        if (gnt[0] !== 1'b1 || mreq[0] !== 1'b1 || maddr[0] !== 12'(16 + k)) begin
          failures++;
          $display("FAIL b2b_grant cyc=%0d gnt=%b mreq=%b maddr=%0d (want 1 1 %0d)",
                   k, gnt[0], mreq[0], maddr[0], 16 + k);
        end
      end
      if (k >= 1 && k <= 4) begin
        checks++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== d[k-1] || err[0] !== 1'b0) begin
          failures++;
          $display("FAIL b2b_resp cyc=%0d rvalid=%b rdata=%h err=%b (want 1 %h 0)",
                   k, rvalid[0], rdata[0], err[0], d[k-1]);
        end
      end
      if (k == 5) begin
        checks++;
        if (rvalid[0] !== 1'b0) begin
          failures++;
          $display("FAIL b2b_tail rvalid=%b (want 0)", rvalid[0]);
        end
      end
    end
  endtask

  task automatic test_wait_states;
    int lat; logic [31:0] rd; logic e, mq; logic [11:0] ma;
    issue(1, 1'b1, 4'hF, BASE + 32'h80, 32'h1234_5678, lat, rd, e, mq, ma);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = BASE + 32'h80;
    #1;
    checks++;
    if (gnt[1] !== 1'b1) begin
      failures++;
      $display("FAIL ws3_grant gnt=%b (want 1)", gnt[1]);
    end
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk); #1;
      checks++;
      if (gnt[1] !== 1'b0 || rvalid[1] !== 1'b0) begin
        failures++;
        $display("FAIL ws3_wait cyc=T+%0d gnt=%b rvalid=%b (want 0 0)", j, gnt[1], rvalid[1]);
      end
    end
    @(negedge clk);
    req[1] = 1'b0;
    #1;
    checks++;
    if (rvalid[1] !== 1'b1 || rdata[1] !== 32'h1234_5678 || err[1] !== 1'b0) begin
      failures++;
      $display("FAIL ws3_resp rvalid=%b rdata=%h err=%b (want 1 12345678 0)",
               rvalid[1], rdata[1], err[1]);
    end
  endtask

  task automatic test_reset_mid_txn;
    int lat; logic [31:0] rd; logic e, mq; logic [11:0] ma;
    int seen;
    issue(2, 1'b0, 4'hF, 32'h0020_0000, 32'h0, lat, rd, e, mq, ma);
    exp_errs[2]++;
    checks++;
    if (lat !== 6 || e !== 1'b1) begin
      failures++;
      $display("FAIL ws5_err_resp lat=%0d err=%b (want 6 1)", lat, e);
    end
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = BASE + 32'h100;
    @(negedge clk);                       // T+1
    req[2] = 1'b0;
    @(negedge clk);                       // T+2
    rst = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) exp_errs[g] = 0;
    checks++;
    if (rvalid[2] !== 1'b0 || errcnt[2] !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset rvalid=%b errcnt=%0d (want 0 0)", rvalid[2], errcnt[2]);
    end
    @(negedge clk);                       // T+3
    rst = 1'b0;
    @(negedge clk);                       // T+4
    req[2] = 1'b1; addr[2] = BASE + 32'h100;
    #1;
    checks++;
    if (gnt[2] !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_grant gnt=%b (want 1)", gnt[2]);
    end
    seen = 0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      req[2] = 1'b0;
      #1;
      if (rvalid[2]) seen = (seen == 0) ? j : seen;
    end
    checks++;
    if (seen !== 6) begin
      failures++;
      $display("FAIL post_reset_rvalid first_rvalid_cycle=%0d (want 6)", seen);
    end
  endtask

  task automatic test_random;
    int lat; logic [31:0] rd; logic e, mq; logic [11:0] ma;
    logic [31:0] a, d, exp_rd;
    logic [3:0] b;
    logic w;
    bit ok;
    for (int g = 0; g < 2; g++) begin
      for (int n = 0; n < 40; n++) begin
        case ($urandom_range(0, 9))
          0: a = BASE - 32'(4 * $urandom_range(1, 16));
          1: a = BASE + 32'd16384 + 32'(4 * $urandom_range(0, 3));
          2: a = BASE + 32'd16380;
          3: a = $urandom;
          default: a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        endcase
        w = 1'($urandom_range(0, 1));
        b = 4'($urandom);
        d = $urandom;
        exp_rd = (!w && win(a)) ? shadow_rd(g, a) : 32'd0;
        issue(g, w, b, a, d, lat, rd, e, mq, ma);
        if (!win(a)) exp_errs[g]++;
        ok = (lat == 1 + ws_of(g)) && (mq === win(a)) && (e === !win(a)) && (rd === exp_rd);
        if (win(a)) ok = ok && (ma === 12'((a - BASE) / 4));
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL random inst=%0d addr=%h we=%b lat=%0d mreq=%b maddr=%0d err=%b rdata=%h (want lat=%0d mreq=%b err=%b rdata=%h)",
                   g, a, w, lat, mq, ma, e, rd, 1 + ws_of(g), win(a), !win(a), exp_rd);
        end
        @(negedge clk); #1;
        checks++;
        if (errcnt[g] !== 16'(exp_errs[g])) begin
          failures++;
          $display("FAIL random_err_count inst=%0d got=%0d want=%0d", g, errcnt[g], exp_errs[g]);
        end
      end
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      req[g] = 1'b0; we[g] = 1'b0; be[g] = 4'h0; addr[g] = '0; wdata[g] = '0;
      exp_errs[g] = 0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    test_reset;
    @(negedge clk);
    rst = 1'b0;
    test_write_read;
    test_byte_enable;
    test_out_of_range;
    test_back_to_back;
    test_wait_states;
    test_reset_mid_txn;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
